onehot_pulse_decoder: RTL
=========================

Name: onehot_pulse_decoder

Overview:
- Sequential inverse of the team's 8-to-3 one-hot encoder.
- Accepts a binary code through a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles, then returns the bus to all-zero.
- Sits downstream of code producers (encoder, sequencers) and drives one-hot strobe/select fabrics that must see clean, timed pulses.

Parameters:
- IN_W, 3, width of the binary code; output width is 2**IN_W.
- HOLD_W, 4, width of the per-transaction hold-count field.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  block enable; low forces idle, zero output, no accepts.
- in_valid  input  1  code/hold presented.
- in_ready  output  1  block can accept this cycle.
- in_code  input  IN_W  binary index to decode.
- in_hold  input  HOLD_W  pulse length in cycles; 0 treated as 1.
- out  output  2**IN_W  one-hot decoded bus; all-zero when idle.
- out_valid  output  1  high exactly when out is non-zero.
- done  output  1  high on the final cycle of each completed pulse.

Behaviour:
- Registers: state {IDLE, DRIVE}, code_q[IN_W], cnt[HOLD_W].
- Reset (rst_n low, asynchronous): state=IDLE, code_q=0, cnt=0. Consequently out=0, out_valid=0, done=0 and in_ready=0 while rst_n is low, and in_ready=enable immediately after release.
- Outputs are decoded combinationally from registers only, never from inputs:
  - out = (state==DRIVE) ? (1<<code_q) : 0.
  - out_valid = (state==DRIVE).
  - done = (state==DRIVE && cnt==0).
  - in_ready = enable && (state==IDLE || cnt==0).
- Accept: in_valid && in_ready at rising edge k → code_q=in_code, cnt=max(in_hold,1)-1, state=DRIVE.
- Pulse timing: out is one-hot from cycle k+1 for exactly max(in_hold,1) cycles. Latency from accept to output is 1 cycle.
- DRIVE, cnt>0, enable high: cnt decrements each edge; code_q holds; input ignored (in_ready=0).
- DRIVE, cnt==0 (done high):
  - If an accept occurs this edge, reload code_q/cnt and stay in DRIVE. Back-to-back pulses are gap-free; out switches directly from old line to new line.
  - Otherwise go to IDLE.
- enable low in any state: next edge state=IDLE, cnt=0. The pulse is aborted and done is not asserted for the aborted transaction. While enable is low, in_ready=0.
- enable low in the same cycle as done=1: done is still visible that cycle (registered state); the next edge goes to IDLE.
- All in_code values are valid; there is no error case. Every IN_W-bit index maps to exactly one output bit.
- Width rules:
  - cnt is HOLD_W bits, so the maximum pulse is 2**HOLD_W-1 cycles (in_hold all-ones).
  - in_hold=0 and in_hold=1 both yield a 1-cycle pulse.
- out is never multi-hot in any cycle, including across reload and abort edges.

Decomposition:
- Shared package onehot_pkg:
  - state enum type {IDLE, DRIVE}.
  - localparam OUT_W = 2**IN_W helper function.
  - reusable function onehot_of(code).
- One natural sub-module: bin2onehot, a purely combinational IN_W → 2**IN_W decoder instantiated on code_q and gated by state. It is reusable by other blocks and by the bench scoreboard.

Test Plan:
- Reset then single pulse: release rst_n, enable=1, accept code=3'd5, hold=4 → out=8'b0010_0000 for cycles k+1..k+4; done high only at k+4; out=0 at k+5; in_ready low k+1..k+3.
- Hold zero/one equivalence: accept code=0, hold=0, then later code=7, hold=1 → each produces exactly one cycle of out=8'h01 and out=8'h80 respectively, each with done in that cycle.
- Back-to-back: accept code=2, hold=2; present code=6, hold=3 with in_valid held high → out=8'h04 for 2 cycles, then immediately 8'h40 for 3 cycles with no zero cycle between; done pulses twice.
- Abort: accept code=1, hold=8; drop enable on the 3rd drive cycle → out=0 the next cycle, no done; in_ready stays 0 until enable returns, then accept resumes normally.
- Async reset mid-pulse: during a code=4, hold=10 pulse, assert rst_n between clock edges → out, out_valid, done and in_ready go to 0 without waiting for a clock edge; after release, the first accepted code decodes correctly.
- Exhaustive sweep: all 8 codes × holds {0,1,15} against the bin2onehot model → out exactly one-hot and equal to 1<<code every driven cycle; max pulse is 15 cycles; out_valid equals |out every cycle.

Source files
------------

// File: rtl/onehot_pkg.sv
// onehot_pkg: shared types and helpers for the one-hot pulse decoder family.
//   state_t    - decoder FSM state {IDLE, DRIVE}
//   out_w()    - one-hot bus width for a given binary code width
//   onehot_of()- reference one-hot of a code, wide enough for any IN_W <= 8
package onehot_pkg;

    typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

    localparam int MAX_OUT_W = 256;

    function automatic int out_w(input int in_w);
        return 1 << in_w;
    endfunction

    function automatic logic [MAX_OUT_W-1:0] onehot_of(input int unsigned code);
        return MAX_OUT_W'(1) << code;
    endfunction

endpackage

// File: rtl/onehot_pulse_decoder_bin2onehot.sv
// bin2onehot: purely combinational IN_W -> 2**IN_W binary-to-one-hot decoder.
//   code - binary index
//   out  - exactly one bit set, at position code
module bin2onehot #(
    parameter int IN_W = 3
) (
    input  logic [IN_W-1:0]      code,
    output logic [(1<<IN_W)-1:0] out
);

    for (genvar i = 0; i < (1 << IN_W); i++) begin : g_bit
        assign out[i] = (code == IN_W'(i));
    end

endmodule

// File: rtl/onehot_pulse_decoder.sv
// onehot_pulse_decoder: accepts a binary code over valid/ready and drives the
// matching one-hot line for max(hold,1) cycles, then returns the bus to zero.
//   clk, rst_n        - clock, asynchronous active-low reset
//   enable            - low forces idle, zero output, no accepts
//   in_valid/in_ready - input handshake; in_code/in_hold carried with it
//   out               - one-hot bus, all-zero when idle
//   out_valid         - high exactly when out is non-zero
//   done              - high on the final cycle of each completed pulse
module onehot_pulse_decoder
    import onehot_pkg::*;
#(
    parameter int IN_W   = 3,
    parameter int HOLD_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_code,
    input  logic [HOLD_W-1:0]        in_hold,
    output logic [out_w(IN_W)-1:0]   out,
    output logic                     out_valid,
    output logic                     done
);

    state_t              state, state_nx;
    logic [IN_W-1:0]     code_q, code_nx;
    logic [HOLD_W-1:0]   cnt, cnt_nx;
    logic [out_w(IN_W)-1:0] dec;
    logic                last, accept;

    bin2onehot #(.IN_W(IN_W)) u_dec (.code(code_q), .out(dec));

    assign last      = (cnt == '0);
    // rst_n gates ready so nothing looks acceptable while reset is held
    assign in_ready  = rst_n && enable && (state == IDLE || last);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DRIVE);
    assign out       = out_valid ? dec : '0;
    assign done      = out_valid && last;

    always_comb begin
        state_nx = state;
        code_nx  = code_q;
        cnt_nx   = cnt;
        if (!enable) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (accept) begin
            // reload also covers the done cycle, giving gap-free back-to-back pulses
            state_nx = DRIVE;
            code_nx  = in_code;
            cnt_nx   = (in_hold == '0) ? '0 : in_hold - HOLD_W'(1);
        end else if (state == DRIVE) begin
            state_nx = last ? IDLE : DRIVE;
            cnt_nx   = last ? cnt : cnt - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            code_q <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            code_q <= code_nx;
            cnt    <= cnt_nx;
        end
    end

endmodule
